// File: rtl/lsdalu_pkg.sv
// lsdalu_pkg: shared opcodes, arbiter FSM state encoding and requester-id type
package lsdalu_pkg;
  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_OR    = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  typedef logic rid_t;
  localparam rid_t RID0 = 1'b0;
  localparam rid_t RID1 = 1'b1;
endpackage

// File: rtl/lsdalu.sv
// lsdalu: 8-bit combinational ALU
//   a, b  : operands (two's complement)
//   opr   : opcode (lsdalu_pkg OP_*)
//   r     : result
//   flags : {N, Z, C, V}; C is carry for add, borrow for sub, shifted-out bit for shifts
module lsdalu
  import lsdalu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opr,
  output logic [7:0] r,
  output logic [3:0] flags
);
  logic [8:0] sum, dif;
  logic       c, v;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    {c, r} = {1'b0, b};
    v = 1'b0;
    case (opr)
      OP_PASSB: {c, r} = {1'b0, b};
      OP_SUB: begin
        {c, r} = dif;
        v = (a[7] != b[7]) && (dif[7] != a[7]);
      end
      OP_ADD: begin
        {c, r} = sum;
        v = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      OP_XOR: {c, r} = {1'b0, a ^ b};
      OP_SHR: {c, r} = {a[0], 1'b0, a[7:1]};
      OP_SHL: {c, r} = {a[7], a[6:0], 1'b0};
      OP_AND: {c, r} = {1'b0, a & b};
      OP_OR:  {c, r} = {1'b0, a | b};
      default: {c, r} = {1'b0, b};
    endcase
  end
  assign flags = {r[7], r == 8'h00, c, v};
endmodule

// File: rtl/lsdalu_arbiter.sv
// lsdalu_arbiter: two-requester arbiter sharing one lsdalu (grant -> exec -> done)
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   req0/1              : level requests, held until the matching done
//   a0/b0/opr0, a1/...  : per-requester operands and opcode
//   gnt0/1              : pulse in the cycle the winner's operands are captured
//   done0/1             : pulse in the cycle r/flags hold that requester's result
//   r, flags            : registered ALU result and flags, held until the next EXEC
//   busy                : FSM not IDLE
//   cnt0/1              : saturating done counters, only with LSDALU_ARB_STATS_EN
//   FIXED_PRIO          : 0 round-robin, 1 requester 0 wins every tie
module lsdalu_arbiter
  import lsdalu_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [2:0] opr0,
  input  logic [2:0] opr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] r,
  output logic [3:0] flags,
`ifdef LSDALU_ARB_STATS_EN
  output logic [7:0] cnt0,
  output logic [7:0] cnt1,
`endif
  output logic       busy
);
  state_t     state, state_nx;
  rid_t       id, rr, win;
  logic       any;
  logic [7:0] la, lb, alu_r;
  logic [2:0] lop;
  logic [3:0] alu_f;
  // Gated by reset_n so no grant is visible while reset is asserted.
  assign any = reset_n & (req0 | req1);
  // rr names the requester that wins the next tie.
  assign win = (req0 & req1) ? (FIXED_PRIO ? RID0 : rr) : (req1 ? RID1 : RID0);
  always_comb begin
    state_nx = (state == IDLE) ? (any ? EXEC : IDLE) : (state == EXEC) ? DONE : IDLE;
    gnt0     = (state == IDLE) & any & (win == RID0);
    gnt1     = (state == IDLE) & any & (win == RID1);
    done0    = (state == DONE) & (id == RID0);
    done1    = (state == DONE) & (id == RID1);
    busy     = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id    <= RID0;
      rr    <= RID0;
      la    <= '0;
      lb    <= '0;
      lop   <= '0;
      r     <= '0;
      flags <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        id  <= win;
        la  <= win ? a1 : a0;
        lb  <= win ? b1 : b0;
        lop <= win ? opr1 : opr0;
      end
      if (state == EXEC) begin
        r     <= alu_r;
        flags <= alu_f;
      end
      if (state == DONE) rr <= ~id;
    end
  end
`ifdef LSDALU_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (done0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (done1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif
  lsdalu u_alu (
    .a    (la),
    .b    (lb),
    .opr  (lop),
    .r    (alu_r),
    .flags(alu_f)
  );
endmodule

// File: tb/tb_lsdalu_arbiter.sv
// tb_lsdalu_arbiter: directed scenarios plus randomized traffic against a cycle-count reference model
module tb_lsdalu_arbiter;
  logic       clock = 1'b0, reset_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic [2:0] opr0 = 3'd0, opr1 = 3'd0;
  logic [1:0] gnt_m, gnt_f, done_m, done_f;
  logic       busy_m, busy_f;
  logic [7:0] r_m, r_f;
  logic [3:0] flags_m, flags_f;
`ifdef LSDALU_ARB_STATS_EN
  logic [7:0] cnt0_m, cnt1_m, cnt0_f, cnt1_f;
`endif
  int passed = 0, total = 0;

  always #5 clock = ~clock;

  lsdalu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .opr0(opr0), .opr1(opr1),
    .gnt0(gnt_m[0]), .gnt1(gnt_m[1]), .done0(done_m[0]), .done1(done_m[1]),
    .r(r_m), .flags(flags_m),
`ifdef LSDALU_ARB_STATS_EN
    .cnt0(cnt0_m), .cnt1(cnt1_m),
`endif
    .busy(busy_m));

  lsdalu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .opr0(opr0), .opr1(opr1),
    .gnt0(gnt_f[0]), .gnt1(gnt_f[1]), .done0(done_f[0]), .done1(done_f[1]),
    .r(r_f), .flags(flags_f),
`ifdef LSDALU_ARB_STATS_EN
    .cnt0(cnt0_f), .cnt1(cnt1_f),
`endif
    .busy(busy_f));

  // Reference ALU in integer arithmetic; returns {r, N, Z, C, V}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ua, ub, sa, sb, res, sres;
    logic c, v;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; res = ub;
    case (op)
      3'd1: begin res = ua - ub; c = ua < ub; sres = sa - sb; v = sres < -128 || sres > 127; end
      3'd2: begin res = ua + ub; c = res > 255; sres = sa + sb; v = sres < -128 || sres > 127; end
      3'd3: res = ua ^ ub;
      3'd4: begin res = ua / 2; c = (ua % 2) == 1; end
      3'd5: begin res = ua * 2; c = ua > 127; end
      3'd6: res = ua & ub;
      3'd7: res = ua | ub;
      default: res = ub;
    endcase
    res = res & 255;
    return {res[7:0], res > 127, res == 0, c, v};
  endfunction

  task automatic do_reset;
    @(negedge clock);
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({gnt_m, done_m, busy_m, r_m, flags_m} !== 17'd0)
      $display("FAIL reset_main got %h want 0", {gnt_m, done_m, busy_m, r_m, flags_m});
    else passed++;
    total++;
    if ({gnt_f, done_f, busy_f, r_f, flags_f} !== 17'd0)
      $display("FAIL reset_fp got %h want 0", {gnt_f, done_f, busy_f, r_f, flags_f});
    else passed++;
`ifdef LSDALU_ARB_STATS_EN
    total++;
    if ({cnt0_m, cnt1_m} !== 16'd0) $display("FAIL reset_cnt got %h want 0", {cnt0_m, cnt1_m});
    else passed++;
`endif
  endtask

  task automatic test_single;
    do_reset;
    req0 = 1'b1; a0 = 8'd10; b0 = 8'd3; opr0 = 3'b010;
    #1;
    total++;
    if (gnt_m !== 2'b01 || busy_m !== 1'b0) $display("FAIL single_gnt gnt=%b busy=%b want 01/0", gnt_m, busy_m);
    else passed++;
    @(negedge clock); #1;
    total++;
    if (gnt_m !== 2'b00 || done_m !== 2'b00 || busy_m !== 1'b1)
      $display("FAIL single_exec gnt=%b done=%b busy=%b want 00/00/1", gnt_m, done_m, busy_m);
    else passed++;
    @(negedge clock); #1;
    total++;
    if (done_m !== 2'b01 || r_m !== 8'd13 || flags_m !== 4'h0)
      $display("FAIL single_done done=%b r=%0d flags=%h want 01/13/0", done_m, r_m, flags_m);
    else passed++;
    req0 = 1'b0;
    @(negedge clock); #1;
    total++;
    if (busy_m !== 1'b0 || done_m !== 2'b00 || r_m !== 8'd13)
      $display("FAIL single_hold busy=%b done=%b r=%0d want 0/00/13", busy_m, done_m, r_m);
    else passed++;
  endtask

  task automatic test_tie;
    do_reset;
    req0 = 1'b1; a0 = 8'd10; b0 = 8'd10; opr0 = 3'b001;
    req1 = 1'b1; a1 = 8'hA5; b1 = 8'hAA; opr1 = 3'b011;
    #1;
    total++;
    if ({gnt_m, gnt_f} !== 4'b0101) $display("FAIL tie_first gnt=%b/%b want 01/01", gnt_m, gnt_f);
    else passed++;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (done_m !== 2'b01 || r_m !== 8'h00 || flags_m !== 4'h4)
      $display("FAIL tie_done0 done=%b r=%h flags=%h want 01/00/4", done_m, r_m, flags_m);
    else passed++;
    req0 = 1'b0;
    @(negedge clock); #1;
    total++;
    if ({gnt_m, gnt_f} !== 4'b1010) $display("FAIL tie_second gnt=%b/%b want 10/10", gnt_m, gnt_f);
    else passed++;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (done_m !== 2'b10 || r_m !== 8'h0F || flags_m !== 4'h0 || r_f !== 8'h0F)
      $display("FAIL tie_done1 done=%b r=%h flags=%h rfp=%h want 10/0f/0/0f", done_m, r_m, flags_m, r_f);
    else passed++;
    req1 = 1'b0;
  endtask

  task automatic test_alternate;
    logic [7:0] seq_m, seq_f;
    seq_m = 8'd0; seq_f = 8'd0;
    do_reset;
    req0 = 1'b1; req1 = 1'b1;
    repeat (12) begin
      #1;
      if (gnt_m != 2'b00) seq_m = {seq_m[5:0], gnt_m};
      if (gnt_f != 2'b00) seq_f = {seq_f[5:0], gnt_f};
      @(negedge clock);
    end
    req0 = 1'b0; req1 = 1'b0;
    total++;
    if (seq_m !== 8'h66) $display("FAIL alternate_rr grants=%b want 01100110", seq_m);
    else passed++;
    total++;
    if (seq_f !== 8'h55) $display("FAIL alternate_fixed grants=%b want 01010101", seq_f);
    else passed++;
  endtask

  task automatic test_operand_hold;
    do_reset;
    req0 = 1'b1; a0 = 8'd23; b0 = 8'd0; opr0 = 3'b101;
    #1;
    total++;
    if (gnt_m !== 2'b01) $display("FAIL hold_gnt gnt=%b want 01", gnt_m);
    else passed++;
    @(negedge clock);
    a0 = 8'd99;
    @(negedge clock); #1;
    total++;
    if (done_m !== 2'b01 || r_m !== 8'd46 || flags_m !== 4'h0)
      $display("FAIL hold_result done=%b r=%0d flags=%h want 01/46/0", done_m, r_m, flags_m);
    else passed++;
    req0 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic seen;
    do_reset;
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd7; opr0 = 3'b000;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (done_m !== 2'b01 || r_m !== 8'd7) $display("FAIL mid_first done=%b r=%0d want 01/7", done_m, r_m);
    else passed++;
    a0 = 8'd20; opr0 = 3'b010;
    @(negedge clock); #1;
    total++;
    if (gnt_m !== 2'b01) $display("FAIL mid_regrant gnt=%b want 01", gnt_m);
    else passed++;
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (busy_m !== 1'b0 || r_m !== 8'd0 || flags_m !== 4'h0 || gnt_m !== 2'b00)
      $display("FAIL mid_async busy=%b r=%0d flags=%h gnt=%b want 0/0/0/00", busy_m, r_m, flags_m, gnt_m);
    else passed++;
    req0 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock); #1;
      if (done_m != 2'b00 || busy_m != 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL mid_no_done saw done/busy after reset, want none");
    else passed++;
  endtask

  task automatic test_random;
    int         active[2], start[2], rs[2];
    logic       last[2], mid[2], w, eb;
    logic [7:0] er[2];
    logic [3:0] ef[2];
    logic [11:0] pend[2];
    logic [16:0] obs[2], exp;
    logic [1:0] eg, ed, eg0, ed0;
    do_reset;
    for (int d = 0; d < 2; d++) begin
      active[d] = 0; start[d] = 0; rs[d] = 0; last[d] = 1'b1; mid[d] = 1'b0;
      er[d] = 8'd0; ef[d] = 4'd0; pend[d] = 12'd0;
    end
    eg0 = 2'b00; ed0 = 2'b00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      if (rs[0] != 1) begin a0 = 8'($urandom); b0 = 8'($urandom); opr0 = 3'($urandom); end
      if (rs[1] != 1) begin a1 = 8'($urandom); b1 = 8'($urandom); opr1 = 3'($urandom); end
      for (int i = 0; i < 2; i++)
        if (rs[i] == 0 && $urandom_range(0, 2) == 0) rs[i] = 1;
      req0 = rs[0] == 1 || (rs[0] == 2 && $urandom_range(0, 1) == 1);
      req1 = rs[1] == 1 || (rs[1] == 2 && $urandom_range(0, 1) == 1);
      #1;
      obs[0] = {gnt_m, done_m, busy_m, r_m, flags_m};
      obs[1] = {gnt_f, done_f, busy_f, r_f, flags_f};
      for (int d = 0; d < 2; d++) begin
        eg = 2'b00; ed = 2'b00; eb = 1'b0;
        if (active[d] != 0 && cyc == start[d] + 1) eb = 1'b1;
        else if (active[d] != 0 && cyc == start[d] + 2) begin
          eb = 1'b1; ed[mid[d]] = 1'b1; er[d] = pend[d][11:4]; ef[d] = pend[d][3:0]; active[d] = 0;
        end else if (req0 || req1) begin
          w = (req0 && req1) ? ((d == 1) ? 1'b0 : ~last[d]) : req1;
          eg[w] = 1'b1; last[d] = w; mid[d] = w; active[d] = 1; start[d] = cyc;
          pend[d] = w ? alu_ref(a1, b1, opr1) : alu_ref(a0, b0, opr0);
        end
        exp = {eg, ed, eb, er[d], ef[d]};
        total++;
        if (obs[d] !== exp) $display("FAIL random dut%0d cyc %0d got %h want %h", d, cyc, obs[d], exp);
        else passed++;
        if (d == 0) begin eg0 = eg; ed0 = ed; end
      end
      for (int i = 0; i < 2; i++) begin
        if (eg0[i]) rs[i] = 2;
        if (ed0[i]) rs[i] = 0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

`ifdef LSDALU_ARB_STATS_EN
  task automatic test_stats;
    do_reset;
    req1 = 1'b1; a1 = 8'd1; b1 = 8'd2; opr1 = 3'b010;
    repeat (905) @(negedge clock);
    req1 = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    total++;
    if (cnt1_m !== 8'd255 || cnt0_m !== 8'd0)
      $display("FAIL stats_sat cnt1=%0d cnt0=%0d want 255/0", cnt1_m, cnt0_m);
    else passed++;
    total++;
    if (cnt1_f !== 8'd255 || cnt0_f !== 8'd0)
      $display("FAIL stats_sat_fp cnt1=%0d cnt0=%0d want 255/0", cnt1_f, cnt0_f);
    else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_alternate;
    test_operand_hold;
    test_reset_mid;
    test_random;
`ifdef LSDALU_ARB_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lsdalu_arbiter.md
LSDALU_ARBITER -- requirements
Module: lsdalu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 The block SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: level request from requester 0 and requester 1.
REQ-005 The block SHALL have ports a0, b0, a1 and b1, input, 8 bits each: per-requester operands, two's complement.
REQ-006 The block SHALL have ports opr0 and opr1, input, 3 bits each: per-requester ALU opcode (000 B, 001 A-B, 010 A+B, 011 xor, 100 >>1, 101 <<1, 110 and, 111 or).
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse when the requester's operands are captured.
REQ-008 The block SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse when r/flags are valid for that requester.
REQ-009 The block SHALL have port r, output, 8 bits: registered ALU result.
REQ-010 The block SHALL have port flags, output, 4 bits: registered ALU FLAGS, passed unmodified.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-013 In IDLE with any req high, the FSM SHALL select a winner, latch its a/b/opr, pulse its gnt, record its id, and go to EXEC next cycle.
REQ-014 In EXEC, the block SHALL drive the ALU from the latched operands, register R into r and FLAGS into flags at the clock edge, and go to DONE.
REQ-015 In DONE, the block SHALL pulse done for the recorded id, update the round-robin pointer to the other requester, and return to IDLE.
REQ-016 Latency SHALL be exactly 2 cycles from the gnt cycle to the done cycle; throughput SHALL be one operation per 3 cycles.
REQ-017 Round-robin: when both req are high in IDLE, the requester not served last SHALL win; after reset, requester 0 SHALL win.
REQ-018 With FIXED_PRIO=1, requester 0 SHALL win on every tie.
REQ-019 A requester SHALL hold req until its done; req still high in the cycle after done SHALL be treated as a new request.
REQ-020 Operand changes after gnt SHALL NOT affect the result in flight.
REQ-021 A req dropped between gnt and done SHALL NOT abort the operation; done SHALL still pulse.
REQ-022 r and flags SHALL hold their last values until the next EXEC.
REQ-023 At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-024 With reset_n low, the FSM SHALL enter IDLE immediately (asynchronously), with gnt0/1=0, done0/1=0, busy=0, r=8'h00, flags=4'h0, RR pointer=requester 0 and latched operands=0.
REQ-025 A reset mid-operation SHALL discard the operation, and no done SHALL be issued for it.

Configuration
REQ-026 With LSDALU_ARB_STATS_EN defined, the block SHALL add outputs cnt0 and cnt1 (8 bits each, reset 0), each incrementing on its done and saturating at 255.
REQ-027 With LSDALU_ARB_STATS_EN not defined, those ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-028 Package lsdalu_pkg SHALL hold the opcode constants, the FSM state encoding and the requester-id type.
REQ-029 The block SHALL instantiate exactly one existing lsdalu as a sub-module; it SHALL be the only arithmetic in the block.

Verification
REQ-030 Scenario: req0 only, opr0=010, a0=10, b0=3 -> gnt0 at T, done0 at T+2, r=13.
REQ-031 Scenario: req0 and req1 together from reset, opr0=001 a0=10 b0=10, opr1=011 a1=8'hA5 b1=8'hAA -> requester 0 first (r=0, zero flag set), then requester 1 (r=8'h0F).
REQ-032 Scenario: both req held continuously -> grants alternate 0,1,0,1; with FIXED_PRIO=1 -> only requester 0 is served.
REQ-033 Scenario: change a0 to 99 one cycle after gnt0, with a0=23 opr0=101 -> r=46.
REQ-034 Scenario: assert reset_n=0 during EXEC -> busy=0, r=0, and no done pulse follows.
REQ-035 Scenario: LSDALU_ARB_STATS_EN defined, 300 served req1 operations -> cnt1=255, cnt0=0.
